// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on load&ready, first bit on so one cycle later.
// Not flow-controlled downstream; ready reopens on the last bit so words can stream back-to-back.
module p2s_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  output logic             ready,
  output logic             so,
  output logic             so_vld,
  output logic             sof,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             so_nxt, so_vld_nxt, sof_nxt, done_nxt;
  logic             accept;

  assign ready  = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
  assign accept = load && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      so     <= 1'b0;
      so_vld <= 1'b0;
      sof    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      so     <= so_nxt;
      so_vld <= so_vld_nxt;
      sof    <= sof_nxt;
      done   <= done_nxt;
    end
  end

  // The first bit is taken straight from pi so it lands on so the cycle after
  // acceptance; the shift register then holds only the bits still to be sent.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
    so_nxt     = 1'b0;
    so_vld_nxt = 1'b0;
    sof_nxt    = 1'b0;
    done_nxt   = 1'b0;
    if (accept) begin
      state_nxt  = SHIFT;
      cnt_nxt    = '0;
      so_vld_nxt = 1'b1;
      sof_nxt    = 1'b1;
      so_nxt     = MSB_FIRST ? pi[WIDTH-1] : pi[0];
      shreg_nxt  = MSB_FIRST ? {pi[WIDTH-2:0], 1'b0} : {1'b0, pi[WIDTH-1:1]};
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt    = cnt + 1'b1;
        so_vld_nxt = 1'b1;
        done_nxt   = (cnt == PRE_LAST);
        so_nxt     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        shreg_nxt  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: three instances (4-bit MSB-first, 4-bit LSB-first, 8-bit LSB-first) against a bit-stream model.
module tb_p2s_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] load;
  logic [7:0] pi_a [3];
  logic [2:0] ready, so, so_vld, sof, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p2s_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load[0]), .pi(pi_a[0][3:0]), .ready(ready[0]),
    .so(so[0]), .so_vld(so_vld[0]), .sof(sof[0]), .done(done[0]));
  p2s_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load[1]), .pi(pi_a[1][3:0]), .ready(ready[1]),
    .so(so[1]), .so_vld(so_vld[1]), .sof(sof[1]), .done(done[1]));
  p2s_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load[2]), .pi(pi_a[2]), .ready(ready[2]),
    .so(so[2]), .so_vld(so_vld[2]), .sof(sof[2]), .done(done[2]));

  // Expected output stream per instance: entries {so, so_vld, sof, done}, front = shown now.
  logic [3:0] mq [3][32];
  int         hd [3];
  int         sz [3];

  // Simple MSB-first deserialiser on instance 0 for the loopback check.
  logic [3:0] rx_sr;
  logic [3:0] rx_q [$];
  always @(posedge clk) begin
    if (rst_n && so_vld[0]) begin
      rx_sr <= {rx_sr[2:0], so[0]};
      if (done[0]) rx_q.push_back({rx_sr[2:0], so[0]});
    end
  end

  function automatic int wof(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s out%0d", tag, i), {4'h0, so[i], so_vld[i], sof[i], done[i]}, 8'h00);
      chk($sformatf("%s rdy%0d", tag, i), {7'h0, ready[i]}, 8'h01);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0;
      sz[i] = 0;
    end
  endtask

  // One clock: drive inputs, predict ready, advance the model at the edge, check outputs after it.
  task automatic cycle(input logic [2:0] l, input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2);
    logic [7:0] pv [3];
    logic [2:0] acc;
    logic       b;
    int         w;
    pv = '{p0, p1, p2};
    load = l;
    for (int i = 0; i < 3; i++) pi_a[i] = pv[i];
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready%0d", i), {7'h0, ready[i]}, {7'h0, sz[i] <= 1});
      acc[i] = l[i] && (sz[i] <= 1);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (sz[i] > 0) begin
        hd[i] = (hd[i] + 1) % 32;
        sz[i]--;
      end
      if (acc[i]) begin
        w = wof(i);
        for (int k = 0; k < w; k++) begin
          b = (i == 0) ? pv[i][w-1-k] : pv[i][k];
          mq[i][(hd[i] + sz[i]) % 32] = {b, 1'b1, k == 0, k == w - 1};
          sz[i]++;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("out%0d", i), {4'h0, so[i], so_vld[i], sof[i], done[i]},
          {4'h0, (sz[i] > 0) ? mq[i][hd[i]] : 4'h0});
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(3'b000, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    load  = 3'b000;
    for (int i = 0; i < 3; i++) pi_a[i] = 8'h00;
    #2;
    load = 3'b111;
    for (int i = 0; i < 3; i++) pi_a[i] = 8'hFF;
    #10;
    chk_idle("reset");
    load  = 3'b000;
    rst_n = 1'b1;
    @(negedge clk);
    idle(2);

    // Single words: 1010 MSB-first, 1100 LSB-first, A5 LSB-first
    cycle(3'b111, 8'h0A, 8'h0C, 8'hA5);
    idle(9);

    // Back-to-back on instance 0: 1001 then 0110 accepted in the done cycle
    cycle(3'b001, 8'h09, 8'h00, 8'h00);
    idle(3);
    cycle(3'b001, 8'h06, 8'h00, 8'h00);
    idle(5);

    // Mid-word loads are ignored and not queued
    cycle(3'b111, 8'h0A, 8'h05, 8'h3C);
    cycle(3'b111, 8'h0F, 8'h0F, 8'hFF);
    cycle(3'b111, 8'h0F, 8'h0F, 8'hFF);
    idle(9);

    // Loopback stream 3, C, 9 with no gaps
    rx_q.delete();
    cycle(3'b001, 8'h03, 8'h00, 8'h00);
    idle(3);
    cycle(3'b001, 8'h0C, 8'h00, 8'h00);
    idle(3);
    cycle(3'b001, 8'h09, 8'h00, 8'h00);
    idle(5);
    chk("rx count", 8'(rx_q.size()), 8'd3);
    if (rx_q.size() == 3) begin
      chk("rx word0", {4'h0, rx_q[0]}, 8'h03);
      chk("rx word1", {4'h0, rx_q[1]}, 8'h0C);
      chk("rx word2", {4'h0, rx_q[2]}, 8'h09);
    end

    // Reset mid-word aborts at once; the first edge after release may accept
    cycle(3'b111, 8'h0F, 8'h0F, 8'hFF);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    clear_model();
    rst_n = 1'b1;
    @(negedge clk);
    cycle(3'b111, 8'h05, 8'h0A, 8'h81);
    idle(9);

    for (int n = 0; n < 400; n++)
      cycle(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    idle(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2s_tx.md
Name: p2s_tx

Overview:
- Parallel-to-serial transmitter. It is the sending end of the serial link whose receiving end is the s2p block.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clock.
- Drives a per-bit valid strobe, a start-of-frame marker and an end-of-word pulse, so the receiver can align and capture the word.
- Supports back-to-back words with no idle gap, for streaming into an s2p-style receiver.

Parameters:
- WIDTH, 4, word width in bits. Legal range is WIDTH >= 2.
- MSB_FIRST, 1. When 1, bit WIDTH-1 is sent first. When 0, bit 0 is sent first.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  request to transmit the word on pi
- pi  input  WIDTH  parallel word; sampled only at handshake acceptance
- ready  output  1  block can accept a word this cycle
- so  output  1  serial data out, registered
- so_vld  output  1  so carries a valid bit this cycle, registered
- sof  output  1  high with the first bit of each word, registered
- done  output  1  high with the last bit of each word, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - so = 0, so_vld = 0, sof = 0, done = 0.
  - ready = 1 (derived from state).
  - load is ignored while rst_n is low.
- FSM states: IDLE and SHIFT.
  - ready = (state == IDLE) or (state == SHIFT and cnt == WIDTH-1). It is combinational from registered state.
- Acceptance: a word is accepted on a rising edge where load = 1 and ready = 1.
  - pi is captured into the shift register at that edge.
  - pi changes at any other time have no effect.
  - load while ready = 0 is ignored; it is not queued.
- Latency: the first bit appears on so the cycle after acceptance.
  - In that cycle so_vld = 1, sof = 1 and cnt = 0.
  - Bit k of the word is driven in the cycle with cnt = k, for k = 0..WIDTH-1.
  - Bit order is set by MSB_FIRST.
  - cnt is $clog2(WIDTH) bits wide, increments by 1 each SHIFT cycle and never wraps past WIDTH-1.
- Last bit (cnt == WIDTH-1): so_vld = 1, done = 1, sof = 0.
  - If no word is accepted that cycle: next state is IDLE, with so = 0, so_vld = 0 and done = 0 the following cycle.
  - If a word is accepted that cycle (back-to-back): next state stays SHIFT, cnt reloads to 0, and the new word's first bit follows immediately with sof = 1 and no gap cycle.
- sof and done are never high in the same cycle, since WIDTH >= 2.
- In IDLE, so is held at 0. so never carries stale shift-register data while so_vld = 0.
- Reset mid-word: the transfer is aborted immediately (asynchronously) and outputs return to their reset values.
  - The partial word is discarded and is not resumed after reset releases.
  - The first edge after release may accept a new word.
- The block is not flow-controlled by the receiver. Once a word is accepted, all WIDTH bits are sent on consecutive cycles.

Test Plan:
- Reset: hold rst_n = 0 for 5 ns, then release; check so = so_vld = sof = done = 0 and ready = 1. Pulse load with pi = 4'hF during reset; check no output activity follows.
- Single word, MSB_FIRST = 1: accept pi = 4'b1010. On the next 4 cycles check so = 1, 0, 1, 0 with so_vld = 1, sof on cycle 1 only and done on cycle 4 only. Check ready = 0 on cycles 1–3, then return to IDLE with so = 0.
- LSB-first: MSB_FIRST = 0, pi = 4'b1100. Check so = 0, 0, 1, 1. With WIDTH = 8 and pi = 8'hA5, check the 8 bits come LSB-first with done on bit 8.
- Back-to-back: accept 4'b1001, then hold load = 1 with pi = 4'b0110 during the done cycle. Check the sequence 1, 0, 0, 1, 0, 1, 1, 0 with so_vld continuously high for 8 cycles and sof high on cycles 1 and 5.
- Ignored load and pi: assert load with pi = 4'hF in mid-word cycles 2–3. Check the current word is unaffected, and check no extra word is sent if load drops before the done cycle.
- Loopback: connect so/so_vld/done to an s2p instance with WIDTH = 4, stream words 4'h3, 4'hC and 4'h9, and check that each word appears intact on the receiver's po.
